// File: rtl/mpu_pkg.sv
// Shared definitions for the matrix-multiply operand path.
//   DIM        : maximum square matrix dimension
//   W          : element width in bits
//   IDX_W      : width of the row/column counters
//   state_t    : loader state encoding
//   elem_index : flat element position of (row,col) inside a packed matrix
package mpu_pkg;

    localparam int DIM   = 5;
    localparam int W     = 8;
    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Element (row,col) lives at bits [elem_index*W +: W]. The stride is
    // always the maximum dimension, so a small matrix occupies the
    // top-left corner of the packed vector.
    function automatic int elem_index(input int row, input int col, input int dim);
        return row * dim + col;
    endfunction

endpackage

// File: rtl/mpu_index_counter.sv
// Row-major (row,col) sequencer for a size x size matrix.
//   clk, rst : clock, synchronous active-high reset
//   step     : advance to the next element
//   clear    : return to (0,0); has priority over step
//   size     : effective dimension, 1..DIM
//   row, col : current element coordinates
//   last     : current element is (size-1,size-1)
module mpu_index_counter #(
    parameter int DIM   = 5,
    parameter int IDX_W = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             clear,
    input  logic [7:0]       size,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    logic col_end;

    assign col_end = (8'(col) == size - 8'd1);
    assign last    = col_end && (8'(row) == size - 8'd1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col_end) begin
                col <= '0;
                // Wrap fully after the last element so the next matrix
                // starts at (0,0) without a separate clear.
                row <= last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Loads two square operand matrices from a byte stream:
// size byte, then A row-major, then B row-major.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input byte handshake
//   in_data            : stream byte
//   out_valid/out_ready: operand-set handshake towards the multiply stage
//   matrix_a, matrix_b : packed matrices, element (i,j) at [(i*DIM+j)*W +: W]
//   size               : effective dimension, 1..DIM
//   size_err           : one-cycle pulse after an out-of-range size byte
//   dbg_state          : current loader state
//
// Handshake: a byte moves on a rising edge where in_valid && in_ready; the
// operand set moves on an edge where out_valid && out_ready. Neither ready
// depends combinationally on the matching valid.
module mpu_matrix_loader
    import mpu_pkg::*;
#(
    parameter int DIM = mpu_pkg::DIM,
    parameter int W   = mpu_pkg::W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [W-1:0]       in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIM*DIM*W-1:0] matrix_a,
    output logic [DIM*DIM*W-1:0] matrix_b,
    output logic [7:0]         size,
    output logic               size_err,
    output state_t             dbg_state
);

    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [W-1:0] DIM_W = W'(DIM);

    state_t        state;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          last;
    logic          xfer;
    logic          loading;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign xfer      = in_valid && in_ready;
    assign loading   = (state == LOAD_A) || (state == LOAD_B);
    assign dbg_state = state;

    mpu_index_counter #(
        .DIM   (DIM),
        .IDX_W (IW)
    ) u_index (
        .clk   (clk),
        .rst   (rst),
        .step  (xfer && loading),
        .clear (xfer && (state == IDLE)),
        .size  (size),
        .row   (row),
        .col   (col),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            size     <= 8'd1;
            matrix_a <= '0;
            matrix_b <= '0;
            size_err <= 1'b0;
        end else begin
            size_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        matrix_a <= '0;
                        matrix_b <= '0;
                        if (in_data == '0 || in_data > DIM_W) begin
                            size     <= 8'(DIM);
                            size_err <= 1'b1;
                        end else begin
                            size <= 8'(in_data);
                        end
                        state <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (xfer) begin
                        matrix_a[elem_index(int'(row), int'(col), DIM)*W +: W] <= in_data;
                        if (last) state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        matrix_b[elem_index(int'(row), int'(col), DIM)*W +: W] <= in_data;
                        if (last) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
module tb_mpu_matrix_loader;
    import mpu_pkg::*;

    localparam int DIM = 5;
    localparam int W   = 8;
    localparam int MW  = DIM*DIM*W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [MW-1:0] matrix_a;
    logic [MW-1:0] matrix_b;
    logic [7:0]    size;
    logic          size_err;
    state_t        dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard: every byte the bench streams, in order
    logic [W-1:0]  exp_q[$];
    logic [MW-1:0] exp_a, exp_b;
    logic [7:0]    exp_size;

    mpu_matrix_loader #(.DIM(DIM), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .size      (size),
        .size_err  (size_err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one byte until it is accepted; returns 1 cycle after the edge.
    task automatic send(input logic [W-1:0] d);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n < 50) begin
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    // Stream exp_q[first .. first+count-1]; mode 0 continuous,
    // 1 one idle cycle between bytes, 2 random stalls.
    task automatic stream(input int first, input int count, input int mode);
        for (int k = first; k < first + count; k++) begin
            send(exp_q[k]);
            if (mode == 1) tick();
            else if (mode == 2) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    // Reference: operand set implied by the byte stream in exp_q.
    task automatic model();
        int s;
        s = int'(exp_q[0]);
        if (s == 0 || s > DIM) s = DIM;
        exp_size = 8'(s);
        exp_a = '0;
        exp_b = '0;
        for (int i = 0; i < s; i++)
            for (int j = 0; j < s; j++) begin
                exp_a[(i*DIM+j)*W +: W] = exp_q[1 + i*s + j];
                exp_b[(i*DIM+j)*W +: W] = exp_q[1 + s*s + i*s + j];
            end
    endtask

    task automatic fill_random(input logic [W-1:0] size_byte);
        int s;
        s = int'(size_byte);
        if (s == 0 || s > DIM) s = DIM;
        exp_q.delete();
        exp_q.push_back(size_byte);
        for (int k = 0; k < 2*s*s; k++) exp_q.push_back(W'($urandom_range(0, 255)));
    endtask

    task automatic check_result(input string tag);
        model();
        chk({tag, "_out_valid"}, MW'(out_valid), 1);
        chk({tag, "_in_ready"}, MW'(in_ready), 0);
        chk({tag, "_size"}, MW'(size), MW'(exp_size));
        chk({tag, "_matrix_a"}, matrix_a, exp_a);
        chk({tag, "_matrix_b"}, matrix_b, exp_b);
    endtask

    task automatic release_hold(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_out_valid"}, MW'(out_valid), 0);
        chk({tag, "_idle_in_ready"}, MW'(in_ready), 1);
    endtask

    initial begin
        logic [MW-1:0] hold_a, hold_b;
        logic [7:0]    hold_size;
        logic [W-1:0]  sz;

        // reset, with a byte presented that must be discarded
        in_valid = 1'b1;
        in_data  = 8'd3;
        repeat (3) tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_in_ready", MW'(in_ready), 1);
        chk("rst_out_valid", MW'(out_valid), 0);
        chk("rst_size", MW'(size), 1);
        chk("rst_size_err", MW'(size_err), 0);
        chk("rst_matrix_a", matrix_a, '0);
        chk("rst_matrix_b", matrix_b, '0);

        // size-2 directed load, continuous valid
        exp_q.delete();
        for (int k = 0; k <= 8; k++) exp_q.push_back(W'(k == 0 ? 2 : k));
        stream(0, 1, 0);
        chk("s2_size_err", MW'(size_err), 0);
        stream(1, 7, 0);
        chk("s2_not_yet_valid", MW'(out_valid), 0);
        stream(8, 1, 0);
        check_result("s2");
        chk("s2_a11", MW'(matrix_a[(1*DIM+1)*W +: W]), 4);
        chk("s2_b10", MW'(matrix_b[(1*DIM+0)*W +: W]), 7);

        // hold back-pressure for 10 cycles
        hold_a = matrix_a;
        hold_b = matrix_b;
        hold_size = size;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_in_ready", MW'(in_ready), 0);
            chk("bp_out_valid", MW'(out_valid), 1);
            chk("bp_stable", {matrix_a, matrix_b, size} == {hold_a, hold_b, hold_size} ? 1 : 0, 1);
        end
        release_hold("bp");

        // size-5 load, valid toggling every other cycle
        fill_random(8'd5);
        stream(0, 50, 1);
        chk("s5_not_yet_valid", MW'(out_valid), 0);
        stream(50, 1, 1);
        check_result("s5");
        chk("s5_a44", MW'(matrix_a[(4*DIM+4)*W +: W]), MW'(exp_q[25]));
        chk("s5_b44", MW'(matrix_b[(4*DIM+4)*W +: W]), MW'(exp_q[50]));
        release_hold("s5");

        // out-of-range size byte 9, out_ready high during the load is ignored
        fill_random(8'd9);
        out_ready = 1'b1;
        stream(0, 1, 0);
        chk("s9_size_err_pulse", MW'(size_err), 1);
        chk("s9_size", MW'(size), 5);
        stream(1, 1, 0);
        chk("s9_size_err_cleared", MW'(size_err), 0);
        stream(2, 48, 2);
        out_ready = 1'b0;
        chk("s9_not_yet_valid", MW'(out_valid), 0);
        stream(50, 1, 0);
        check_result("s9");
        release_hold("s9");

        // randomized loads including size 0 and oversized bytes
        for (int t = 0; t < 6; t++) begin
            sz = W'($urandom_range(0, 8));
            fill_random(sz);
            stream(0, exp_q.size(), 2);
            check_result("rnd");
            repeat ($urandom_range(0, 3)) tick();
            release_hold("rnd");
        end

        // reset mid-load after 4 bytes of a size-3 load
        fill_random(8'd3);
        stream(0, 4, 0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hAA;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_in_ready", MW'(in_ready), 1);
        chk("mid_rst_size", MW'(size), 1);
        chk("mid_rst_matrix_a", matrix_a, '0);
        chk("mid_rst_matrix_b", matrix_b, '0);
        exp_q.delete();
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd9);
        exp_q.push_back(8'd7);
        stream(0, 3, 0);
        check_result("s1");
        chk("s1_a00", MW'(matrix_a[W-1:0]), 9);
        chk("s1_b00", MW'(matrix_b[W-1:0]), 7);
        release_hold("s1");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mpu_matrix_loader.md
MPU_MATRIX_LOADER -- requirements
Module: mpu_matrix_loader

Interface
REQ-001 The module SHALL have one clock and a reset that is synchronous and active-high; the ports SHALL be named clk and rst.
REQ-002 The module SHALL have parameter DIM, default 5, giving the maximum matrix dimension.
REQ-003 The module SHALL have parameter W, default 8, giving the element width in bits.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  in_data holds a valid byte.
REQ-007 in_data  input  W  stream byte: size, then A row-major, then B row-major.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 out_valid  output  1  matrix_a, matrix_b and size are complete and stable.
REQ-010 out_ready  input  1  the downstream multiply stage takes the operand set.
REQ-011 matrix_a  output  DIM*DIM*W  element (i,j) at bits [(i*DIM+j)*W +: W].
REQ-012 matrix_b  output  DIM*DIM*W  same packing as matrix_a.
REQ-013 size  output  8  effective dimension, 1..DIM.
REQ-014 size_err  output  1  one-cycle pulse when the received size byte was out of range.

Function
REQ-015 A byte SHALL be transferred only in a cycle where in_valid and in_ready are both 1.
REQ-016 The state machine SHALL have four states:
- IDLE: awaiting the size byte.
- LOAD_A, LOAD_B: loading elements.
- HOLD: presenting the result.
REQ-017 in_ready SHALL be 1 in IDLE, LOAD_A and LOAD_B, and SHALL be 0 in HOLD.
REQ-018 A transfer in IDLE SHALL latch size, zero all elements of both matrices in the same edge, reset row/col to 0, and move to LOAD_A.
REQ-019 A size byte of 0 or greater than DIM SHALL be clamped to DIM, with size_err pulsed high for exactly the following cycle.
REQ-020 Each transfer in LOAD_A or LOAD_B SHALL write in_data to element (row,col) of the active matrix.
REQ-021 Column counter col SHALL wrap from size-1 to 0 and increment row; no element with row>=size or col>=size SHALL ever be written (remaining elements stay 0).
REQ-022 When the transfer at (size-1,size-1) occurs, the machine SHALL go from LOAD_A to LOAD_B (counters cleared), or from LOAD_B to HOLD.
REQ-023 out_valid SHALL equal (state==HOLD), rising the cycle after the last B byte is accepted: latency 1 cycle; total load = 1+2*size*size accepted bytes.
REQ-024 matrix_a, matrix_b and size SHALL remain constant while out_valid is 1.
REQ-025 out_valid and out_ready both 1 SHALL return the machine to IDLE at that edge; in_ready SHALL be 1 the next cycle, with no same-cycle bypass.
REQ-026 Stalls (in_valid=0) SHALL leave state, counters and matrices unchanged.
REQ-027 out_ready while out_valid=0 SHALL be ignored.
REQ-028 All arithmetic SHALL be unsigned; row and col SHALL be $clog2(DIM) bits wide.

Reset
REQ-029 rst asserted at any clock edge, including mid-load or during HOLD, SHALL abort the load and set:
- state to IDLE;
- row, col, matrix_a and matrix_b to 0;
- size to 1;
- out_valid and size_err to 0;
- in_ready to 1 on the first cycle after reset is released.
REQ-030 Bytes presented during reset SHALL be discarded.

Structure
REQ-031 DIM, W, the state encoding and the element-index helper SHALL be defined in the shared package mpu_pkg.
REQ-032 The row/col sequencing SHALL be a single sub-module, mpu_index_counter (inputs: step, clear, size; outputs: row, col, last), instantiated once.
REQ-033 Flattened outputs SHALL connect directly to the downstream multiply stage.

Verification
REQ-034 Size-2 load: stream 2,1,2,3,4,5,6,7,8 with continuous in_valid.
- out_valid rises 1 cycle after byte 9.
- A(0,0..1)=1,2; A(1,0..1)=3,4; B(0,0..1)=5,6; B(1,0..1)=7,8.
- All other elements = 0; size=2.
REQ-035 Size-5 load with in_valid toggling every other cycle: 51 bytes accepted; A(4,4) and B(4,4) hold the 26th and 51st data bytes.
REQ-036 Size byte 9: size_err pulses one cycle, size=5, and 50 element bytes are required before out_valid.
REQ-037 HOLD back-pressure: out_ready low for 10 cycles; then both of the following hold:
- outputs stable and in_ready=0 throughout;
- on out_ready=1, IDLE is reached and in_ready=1 in the next cycle.
REQ-038 rst pulsed after 4 bytes of a size-3 load, then a fresh size-1 load 1,9,7: A(0,0)=9, B(0,0)=7, and all other elements are 0.
